// File: rtl/seg7_scan_display_if.sv
// Capture handshake between a value producer and the seg7_scan_display driver.
// The producer presents bin_in with a bin_valid strobe and watches busy.
interface seg7_scan_display_if #(
    parameter int BIN_W = 10
);
    logic [BIN_W-1:0] bin_in;
    logic             bin_valid;
    logic             busy;

    modport master (output bin_in, output bin_valid, input busy);
    modport slave  (input bin_in, input bin_valid, output busy);
endinterface

// File: rtl/seg7_scan_display.sv
// Binary-to-BCD (double dabble, one bit per clock) multi-digit 7-segment scanner.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module seg7_scan_display #(
    parameter int BIN_W        = 10,
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_scan_display_if.slave   bus,
    output logic                 overflow,
    output logic [6:0]           seg,
    output logic [7:0]           an
);
    localparam int          ACC_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);
    localparam logic [6:0]  DASH    = 7'b0111111;
    localparam logic [6:0]  BLANK   = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                  state_q, state_d;
    logic [BIN_W-1:0]        sr_q, sr_d;
    logic [ACC_W-1:0]        acc_q, acc_d, acc_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pend_q, pend_d;
    logic [ACC_W-1:0]        disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [2:0]              idx_q, idx_d;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    // Double-dabble correction: any BCD nibble of 5 or more would exceed 9 after the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.bin_valid) begin
                    sr_d    = bus.bin_in;
                    acc_d   = '0;
                    pend_d  = 32'(bus.bin_in) > MAX_VAL;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, sr_d} = {acc_adj, sr_q} << 1;
                cnt_d         = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = LOAD;
            end
            LOAD: begin
                disp_d  = acc_q;
                ovf_d   = pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit index only advances when the low refresh bits roll over.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (&refresh_q) idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            refresh_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign overflow = ovf_q;

    logic [3:0] nib;
    logic       upper_zero;

    always_comb begin
        nib        = 4'd0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) nib = disp_q[4*i +: 4];
            if (3'(i) >= idx_q && disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        an = ~(8'd1 << idx_q);
        if (ovf_q) begin
            seg = DASH;
        end else begin
            seg = glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
            if (idx_q != 3'd0 && upper_zero) seg = BLANK;
`endif
        end
    end
endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Parametrised multi-digit 7-segment display driver for the Nexys A7 heading readout and any other numeric value on the board. It accepts a binary value with a valid strobe and converts it to BCD with a sequential double-dabble engine, one bit per clock. It latches the result into a display register and time-multiplexes up to eight active-low digits. Values the configured digit count cannot represent are flagged as overflow and shown as dashes.

## Interface
- `BIN_W`, default 10: width of binary input, 4..20.
- `NUM_DIGITS`, default 4: number of scanned digits, 1..8.
- `REFRESH_BITS`, default 18: each digit is held for 2^REFRESH_BITS clocks; minimum 1.

- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: synchronous, active-high.
- `bin_in` input BIN_W: unsigned value to display.
- `bin_valid` input 1: capture request; sampled only in IDLE.
- `busy` output 1: conversion in progress; high in SHIFT and LOAD.
- `overflow` output 1: currently displayed value exceeded 10^NUM_DIGITS-1.
- `seg` output 7: {g,f,e,d,c,b,a}, active-low.
- `an` output 8: digit enables, active-low one-hot; bits ≥ NUM_DIGITS are always 1.

## Operation
- FSM states: IDLE, SHIFT, LOAD.
- **IDLE**, `bin_valid`=1: capture `bin_in` into the shift register and clear the BCD accumulator (NUM_DIGITS nibbles). Set the pending-overflow flag = (`bin_in` > 10^NUM_DIGITS-1, constant compare). Load bit counter = BIN_W, then go to SHIFT.
- **SHIFT**, each cycle:
  - Add 3 to every accumulator nibble ≥ 5.
  - Shift {accumulator, shift reg} left by 1.
  - Decrement the counter; when it reaches 1 (the last shift), go to LOAD.
- **LOAD**: copy the accumulator to the display register and the pending flag to `overflow`, then go to IDLE.
- `bin_valid` during SHIFT or LOAD is ignored; no queueing.
- Accumulator bits shifted out above NUM_DIGITS nibbles are discarded; display content is then irrelevant because `overflow` forces dashes.
- Scan:
  - The refresh counter advances every clock.
  - The digit index increments when the counter's low REFRESH_BITS bits wrap.
  - The index wraps from NUM_DIGITS-1 to 0.
- Output decode:
  - `an` = ~(1 << index).
  - `seg` = glyph of the display-register nibble at index.
  - If `overflow`=1, `seg` = dash (7'b0111111) on every digit.
- Glyphs (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.

## Timing
- Reset values:
  - State IDLE; `busy`=0, `overflow`=0.
  - Display register all zero; refresh counter 0; index 0.
  - Hence `an`=8'b11111110 and `seg`=7'b1000000 in the cycle after reset.
- Reset mid-conversion: abort immediately and return to reset values; the display shows 0, not the old value.
- `bin_valid` sampled at edge N:
  - `busy`=1 from N+1 through N+BIN_W+1.
  - Display register and `overflow` update at edge N+BIN_W+1.
  - Back in IDLE, with `busy`=0, from N+BIN_W+2.
  - A new `bin_valid` is accepted at N+BIN_W+2 at the earliest.
- Conversion does not disturb the scan; the old value stays displayed until LOAD.
- `seg`/`an` are combinational from registered index, display register and `overflow`. They change in the same cycle as the index; no blanking gap.
- Digit period = 2^REFRESH_BITS clocks; full frame = NUM_DIGITS·2^REFRESH_BITS clocks.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Any digit above index 0 whose nibble and all higher nibbles are zero shows blank (`seg`=1111111); its `an` bit is still asserted.
  - Digit 0 is always shown.
  - Overflow dashes take priority over blanking.
- Not defined: every digit shows its nibble, including leading zeros.

## Test plan
- **Reset:** assert `reset` 2 cycles → `busy`=0, `overflow`=0, `an`=11111110, `seg`=1000000.
- **Conversion (defaults):** `bin_in`=359, `bin_valid` pulse at edge N → `busy` high for exactly 11 cycles. Display becomes 0,3,5,9 (digits 3..0) at edge N+11. With `REFRESH_BITS`=2, stepping through digits 0..3 gives `seg` 0010000, 0010010, 0110000, 1000000. With `LEADING_ZERO_BLANK_EN`, digit 3 is 1111111.
- **Overflow:** `BIN_W`=14, `NUM_DIGITS`=4, `bin_in`=10000 → `overflow`=1 and all digits 0111111. A following `bin_in`=9999 → `overflow`=0 and digits 9,9,9,9.
- **Ignored request:** `bin_valid` with 123 at N, then with 456 at N+3 → display 0123; the second request is dropped.
- **Reset mid-conversion:** `reset` at N+5 during the 359 conversion → `busy`=0 next cycle, display 0000. A request after reset converts normally.
- **Scan wrap:** `NUM_DIGITS`=3, `REFRESH_BITS`=2 → `an` cycles 110, 101, 011 (bits 2..0, upper bits 1), each for 4 clocks. Index wraps to 0 after digit 2; `an[7:3]` stays 11111.
